reram_write_verify_ctrl: RTL

Digital program-and-verify sequencer that drives a single ReRAM cell's SET/RESET/READ drivers using incremental-step pulse programming (ISPP). It sits directly upstream of the cell's bit-line/word-line driver and pulse-amplitude DAC, and consumes the sense-amplifier comparator result. It repeats pulse → settle → verify-read until the cell reaches the requested resistance state or the pulse budget is exhausted.

---
 rtl/reram_write_verify_ctrl.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/reram_write_verify_ctrl.sv
// ISPP program-and-verify sequencer for a single ReRAM cell.
// Drives SET/RESET/READ drivers and the pulse-amplitude DAC code; every output is registered.
module reram_write_verify_ctrl #(
  parameter int VCODE_W    = 6,
  parameter int V_START    = 16,
  parameter int V_STEP     = 4,
  parameter int V_MAX      = 40,
  parameter int PW_CYC     = 4,
  parameter int GAP_CYC    = 2,
  parameter int READ_CYC   = 3,
  parameter int MAX_PULSES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               target_lrs,
  input  logic               abort,
  input  logic               sense_lrs,
  output logic               set_en,
  output logic               reset_en,
  output logic               read_en,
  output logic [VCODE_W-1:0] vcode,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [3:0]         pulse_cnt
);

  localparam int AMP_W = VCODE_W + 1;
  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0]   PW_LAST   = TMR_W'(PW_CYC - 1);
  localparam logic [TMR_W-1:0]   GAP_LAST  = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0]   READ_LAST = TMR_W'(READ_CYC - 1);
  localparam logic [3:0]         CNT_MAX   = 4'(MAX_PULSES);
  localparam logic [VCODE_W-1:0] AMP_START = VCODE_W'(V_START);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_READ = 3'd1,
    PULSE    = 3'd2,
    GAP      = 3'd3,
    VERIFY   = 3'd4,
    ABORTING = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [TMR_W-1:0]   tmr_r, tmr_nxt_s;
  logic [VCODE_W-1:0] amp_r, amp_nxt_s;
  logic               tgt_r, tgt_nxt_s;
  logic [3:0]         cnt_r, cnt_nxt_s;
  logic               pass_r, pass_nxt_s;
  logic               rst_sync_r;
  logic               srst_s;
  logic               abortable_s;

  logic               set_en_r, reset_en_r, read_en_r, busy_r, done_r;
  logic [VCODE_W-1:0] vcode_r;
  logic               set_en_nxt_s, reset_en_nxt_s, read_en_nxt_s, busy_nxt_s, done_nxt_s;
  logic [VCODE_W-1:0] vcode_nxt_s;

  // Amplitude step computed one bit wider so the sum cannot wrap before clamping.
  function automatic logic [VCODE_W-1:0] next_amp(input logic [VCODE_W-1:0] amp);
    logic [AMP_W-1:0] sum;
    sum = {1'b0, amp} + AMP_W'(V_STEP);
    if (sum > AMP_W'(V_MAX)) begin
      next_amp = VCODE_W'(V_MAX);
    end else begin
      next_amp = sum[VCODE_W-1:0];
    end
  endfunction

  // Reset release synchronizer: holds the sequencer idle for the first edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 1'b0;
    end else begin
      rst_sync_r <= 1'b1;
    end
  end

  assign srst_s = ~rst_sync_r;

  // Next-state, timer, amplitude and result bookkeeping.
  always_comb begin
    state_nxt_s = state_r;
    tmr_nxt_s   = tmr_r + TMR_W'(1);
    amp_nxt_s   = amp_r;
    tgt_nxt_s   = tgt_r;
    cnt_nxt_s   = cnt_r;
    pass_nxt_s  = pass_r;
    abortable_s = (state_r == PRE_READ) || (state_r == PULSE) ||
                  (state_r == GAP) || (state_r == VERIFY);
    if (abort && abortable_s) begin
      state_nxt_s = ABORTING;
      tmr_nxt_s   = '0;
      pass_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tmr_nxt_s = '0;
          if (start) begin
            state_nxt_s = PRE_READ;
            tgt_nxt_s   = target_lrs;
            cnt_nxt_s   = 4'd0;
            amp_nxt_s   = AMP_START;
            pass_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        PRE_READ: begin
          if (tmr_r == READ_LAST) begin
            tmr_nxt_s = '0;
            if (sense_lrs == tgt_r) begin
              state_nxt_s = DONE;
              pass_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = PULSE;
              cnt_nxt_s   = cnt_r + 4'd1;
            end
          end else begin
            state_nxt_s = PRE_READ;
          end
        end
        PULSE: begin
          if (tmr_r == PW_LAST) begin
            tmr_nxt_s   = '0;
            state_nxt_s = GAP;
          end else begin
            state_nxt_s = PULSE;
          end
        end
        GAP: begin
          if (tmr_r == GAP_LAST) begin
            tmr_nxt_s   = '0;
            state_nxt_s = VERIFY;
          end else begin
            state_nxt_s = GAP;
          end
        end
        VERIFY: begin
          if (tmr_r == READ_LAST) begin
            tmr_nxt_s = '0;
            if (sense_lrs == tgt_r) begin
              state_nxt_s = DONE;
              pass_nxt_s  = 1'b1;
            end else if (cnt_r == CNT_MAX) begin
              state_nxt_s = DONE;
              pass_nxt_s  = 1'b0;
            end else begin
              state_nxt_s = PULSE;
              amp_nxt_s   = next_amp(amp_r);
              cnt_nxt_s   = cnt_r + 4'd1;
            end
          end else begin
            state_nxt_s = VERIFY;
          end
        end
        ABORTING: begin
          tmr_nxt_s   = '0;
          state_nxt_s = DONE;
        end
        DONE: begin
          tmr_nxt_s   = '0;
          state_nxt_s = IDLE;
        end
        default: begin
          tmr_nxt_s   = '0;
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Output values for the coming cycle, decoded from the next state so the pins come straight off flops.
  always_comb begin
    set_en_nxt_s   = 1'b0;
    reset_en_nxt_s = 1'b0;
    read_en_nxt_s  = 1'b0;
    vcode_nxt_s    = '0;
    done_nxt_s     = 1'b0;
    busy_nxt_s     = 1'b0;
    case (state_nxt_s)
      PRE_READ, VERIFY: begin
        read_en_nxt_s = 1'b1;
        busy_nxt_s    = 1'b1;
      end
      PULSE: begin
        busy_nxt_s  = 1'b1;
        vcode_nxt_s = amp_nxt_s;
        if (tgt_nxt_s) begin
          set_en_nxt_s = 1'b1;
        end else begin
          reset_en_nxt_s = 1'b1;
        end
      end
      GAP, ABORTING: begin
        busy_nxt_s = 1'b1;
      end
      DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      tmr_r   <= '0;
      amp_r   <= '0;
      tgt_r   <= 1'b0;
      cnt_r   <= 4'd0;
      pass_r  <= 1'b0;
    end else if (srst_s) begin
      state_r <= IDLE;
      tmr_r   <= '0;
      amp_r   <= '0;
      tgt_r   <= 1'b0;
      cnt_r   <= 4'd0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tmr_r   <= tmr_nxt_s;
      amp_r   <= amp_nxt_s;
      tgt_r   <= tgt_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pass_r  <= pass_nxt_s;
    end
  end

  // Driver and status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_en_r   <= 1'b0;
      reset_en_r <= 1'b0;
      read_en_r  <= 1'b0;
      vcode_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else if (srst_s) begin
      set_en_r   <= 1'b0;
      reset_en_r <= 1'b0;
      read_en_r  <= 1'b0;
      vcode_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      set_en_r   <= set_en_nxt_s;
      reset_en_r <= reset_en_nxt_s;
      read_en_r  <= read_en_nxt_s;
      vcode_r    <= vcode_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign set_en    = set_en_r;
  assign reset_en  = reset_en_r;
  assign read_en   = read_en_r;
  assign vcode     = vcode_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign pulse_cnt = cnt_r;

endmodule
